// File: rtl/demux32_1_2_pkg.sv
// Shared constants and helpers for the 32-bit datapath blocks.
package demux32_1_2_pkg;

  localparam int WIDTH_DFLT = 32;

  // Bits needed to hold values 0..n-1; constant-foldable for port widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux32_1_2_fifo32_sync.sv
// DEPTH-entry synchronous FIFO; 1-cycle push-to-dout latency, dout zeroed when empty.
// Refuses push when full (no pass-through), ignores pop when empty.
module fifo32_sync
  import demux32_1_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT,
  parameter int DEPTH = 2,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage is not reset: pointers and count define what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux32_1_2.sv
// Buffered 1-to-2 word steering; 1-cycle input-to-output latency through per-output FIFOs.
// in_ready reflects only the selected FIFO's fullness; each output drains on its own valid/ready.
module demux32_1_2
  import demux32_1_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DFLT,
  parameter int DEPTH = 2,
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             valid0,
  input  logic             ready0,
  output logic [WIDTH-1:0] y1,
  output logic             valid1,
  input  logic             ready1,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  logic full0, full1, empty0, empty1;
  logic push0, push1;

  assign in_ready = s ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & ~s;
  assign push1    = in_valid & in_ready & s;
  assign valid0   = ~empty0;
  assign valid1   = ~empty1;

  fifo32_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .din   (a),
    .pop   (ready0),
    .dout  (y0),
    .count (cnt0),
    .full  (full0),
    .empty (empty0)
  );

  fifo32_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   (a),
    .pop   (ready1),
    .dout  (y1),
    .count (cnt1),
    .full  (full1),
    .empty (empty1)
  );

endmodule

// File: tb/tb_demux32_1_2.sv
// Directed and randomized checks of demux32_1_2 against hand-computed values and a queue model.
module tb_demux32_1_2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic        s;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0, y1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [1:0]  cnt0, cnt1;

  int total  = 0;
  int passed = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  demux32_1_2 dut (
    .clk(clk), .rst(rst), .a(a), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .valid0(valid0), .ready0(ready0),
    .y1(y1), .valid1(valid1), .ready1(ready1),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a = '0; s = 1'b0; in_valid = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // 1. reset / idle
    chk("rst_valid0", {31'b0, valid0}, 32'd0);
    chk("rst_valid1", {31'b0, valid1}, 32'd0);
    chk("rst_y0", y0, 32'h0);
    chk("rst_y1", y1, 32'h0);
    chk("rst_cnt0", {30'b0, cnt0}, 32'd0);
    chk("rst_cnt1", {30'b0, cnt1}, 32'd0);
    s = 1'b0; #1;
    chk("rst_rdy_s0", {31'b0, in_ready}, 32'd1);
    s = 1'b1; #1;
    chk("rst_rdy_s1", {31'b0, in_ready}, 32'd1);

    // 2. steering
    in_valid = 1'b1; s = 1'b0; a = 32'hDEADBEEF;
    tick();
    chk("steer_y0_lat1", y0, 32'hDEADBEEF);
    chk("steer_v1_still0", {31'b0, valid1}, 32'd0);
    s = 1'b1; a = 32'h12345678;
    tick();
    in_valid = 1'b0; #1;
    chk("steer_y0", y0, 32'hDEADBEEF);
    chk("steer_y1", y1, 32'h12345678);
    chk("steer_cnt0", {30'b0, cnt0}, 32'd1);
    chk("steer_cnt1", {30'b0, cnt1}, 32'd1);
    ready0 = 1'b1; ready1 = 1'b1;
    tick();
    ready0 = 1'b0; ready1 = 1'b0; #1;
    chk("steer_drain_v0", {31'b0, valid0}, 32'd0);
    chk("steer_drain_y1", y1, 32'h0);

    // 3. backpressure
    in_valid = 1'b1; s = 1'b0; a = 32'h1;
    tick();
    a = 32'h2;
    tick();
    a = 32'h3; #1;
    chk("bp_cnt0_full", {30'b0, cnt0}, 32'd2);
    chk("bp_rdy_s0", {31'b0, in_ready}, 32'd0);
    s = 1'b1; in_valid = 1'b0; #1;
    chk("bp_rdy_s1", {31'b0, in_ready}, 32'd1);
    s = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    chk("bp_cnt0_held", {30'b0, cnt0}, 32'd2);
    ready0 = 1'b1; #1;
    chk("bp_y0_first", y0, 32'h1);
    tick();
    chk("bp_y0_second", y0, 32'h2);
    tick();
    chk("bp_v0_empty", {31'b0, valid0}, 32'd0);
    chk("bp_y0_zero", y0, 32'h0);

    // 4. streaming with pointer wrap
    ready0 = 1'b1; s = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 32'h10 + 32'(i);
      tick();
      chk("stream_y0", y0, 32'h10 + 32'(i));
      chk("stream_cnt0", {30'b0, cnt0}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_v0", {31'b0, valid0}, 32'd0);
    ready0 = 1'b0;

    // 5. reset mid-operation
    in_valid = 1'b1; s = 1'b1; a = 32'hA1;
    tick();
    a = 32'hA2;
    tick();
    chk("mid_cnt1_full", {30'b0, cnt1}, 32'd2);
    rst = 1'b1; ready1 = 1'b1; a = 32'hA3;
    tick();
    rst = 1'b0; in_valid = 1'b0; ready1 = 1'b0; #1;
    chk("mid_cnt1", {30'b0, cnt1}, 32'd0);
    chk("mid_valid1", {31'b0, valid1}, 32'd0);
    chk("mid_y1", y1, 32'h0);
    tick();
    chk("mid_cnt1_after", {30'b0, cnt1}, 32'd0);

    // 6. randomized traffic against queue model
    for (int c = 0; c < 1000; c++) begin
      logic exp_rdy, acc, p0, p1;
      in_valid = 1'($urandom_range(0, 1));
      s        = 1'($urandom_range(0, 1));
      a        = $urandom;
      ready0   = ($urandom_range(0, 3) != 0);
      ready1   = ($urandom_range(0, 2) == 0);
      #1;
      exp_rdy = s ? (q1.size() < 2) : (q0.size() < 2);
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("rnd_y0", y0, (q0.size() > 0) ? q0[0] : 32'h0);
      chk("rnd_y1", y1, (q1.size() > 0) ? q1[0] : 32'h0);
      acc = in_valid && exp_rdy;
      p0  = ready0 && (q0.size() > 0);
      p1  = ready1 && (q1.size() > 0);
      tick();
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (s) q1.push_back(a);
        else   q0.push_back(a);
      end
      chk("rnd_cnt0", {30'b0, cnt0}, 32'(q0.size()));
      chk("rnd_cnt1", {30'b0, cnt1}, 32'(q1.size()));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux32_1_2.md
Name: demux32_1_2

Overview:
- Buffered 1-to-2 steering block for 32-bit words, the dispatch counterpart of the 2-to-1 operand mux.
- One producer presents a word plus a 1-bit select. The word is queued in the FIFO of output 0 or output 1.
- Each output drains independently through a valid/ready handshake.
- Used where one datapath result fans out to two consumers of differing speed, e.g. a result bus feeding a register-file write port and a store path.

Parameters:
- WIDTH, 32, data width of every word path.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  input word.
- s  input  1  destination select: 0 sends to output 0, 1 sends to output 1.
- in_valid  input  1  a and s are valid this cycle.
- in_ready  output  1  word is accepted this cycle if in_valid is also high.
- y0  output  WIDTH  head word of FIFO 0.
- valid0  output  1  FIFO 0 non-empty.
- ready0  input  1  consumer 0 takes y0.
- y1  output  WIDTH  head word of FIFO 1.
- valid1  output  1  FIFO 1 non-empty.
- ready1  input  1  consumer 1 takes y1.
- cnt0  output  clog2(DEPTH+1)  occupancy of FIFO 0.
- cnt1  output  clog2(DEPTH+1)  occupancy of FIFO 1.

Behaviour:
- Reset (synchronous, active-high): on the rising edge with rst=1, all pointers and counts go to 0. valid0=valid1=0, y0=y1=0, cnt0=cnt1=0. rst overrides any push or pop in the same cycle; words in flight are discarded.
- in_ready is combinational: equals !full0 when s=0 and !full1 when s=1. It does not depend on in_valid or on the ready inputs.
- No pass-through when full: a full FIFO refuses a push even if it pops in the same cycle.
- Push: in_valid and in_ready at a rising edge writes a into the tail of the selected FIFO. The other FIFO is unaffected.
- Pop: validN and readyN at a rising edge advances the head of FIFO N. readyN while validN=0 has no effect.
- Latency: a word accepted at edge k appears on yN with validN=1 after edge k (1 cycle). There is no combinational path from a to yN.
- Ordering: strict FIFO per output. No ordering between outputs.
- Output data:
  - yN = head entry while validN=1.
  - yN = 0 while empty, so no stale data is visible.
  - yN is stable while validN=1 and readyN=0.
- Occupancy: cntN goes +1 on push only, -1 on pop only, and is unchanged on simultaneous push and pop. fullN means cntN==DEPTH; validN means cntN!=0.
- Pointer wrap-around: read and write pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Simultaneous push and pop on a FIFO holding 1 entry: the head advances to the new word. validN stays 1 and yN shows the new word after the edge.
- Simultaneous pops on both outputs are independent and both legal.
- in_valid=0: s and a are ignored and no state changes from the input side.

Decomposition:
- Shared include: WIDTH default constant and the clog2 helper function, reused by other 32-bit datapath blocks.
- One sub-module: fifo32_sync. It is a DEPTH-entry synchronous FIFO with push, pop, dout, count, full and empty. It zeroes dout when empty and is instantiated twice.
- demux32_1_2 holds only the select decode (push0 = in_valid & in_ready & ~s, push1 = in_valid & in_ready & s) and the in_ready mux.

Test Plan:
1. Reset, then idle -> valid0=valid1=0, y0=y1=32'h0, cnt0=cnt1=0, in_ready=1 for both s values.
2. Steering: push 32'hDEADBEEF with s=0 and 32'h12345678 with s=1, ready0=ready1=0 -> one cycle later y0=DEADBEEF, y1=12345678, cnt0=cnt1=1.
3. Backpressure: with ready0=0, push 32'h1, 32'h2, 32'h3 to s=0 -> cnt0=2 and in_ready=0 for s=0. The 3rd word is not accepted, and in_ready for s=1 stays 1. Then raise ready0 -> y0 sequence is 1, 2 and the word 3 is never seen.
4. Streaming: ready0=1 held, push 8 consecutive words 32'h10..32'h17 to s=0 -> y0 emits 10..17 in order, one per cycle after one cycle of latency. cnt0 never exceeds 1, and pointers wrap at least 4 times.
5. Reset mid-operation: fill FIFO 1 with 2 words, assert rst one cycle together with in_valid=1, s=1 and ready1=1 -> after the edge cnt1=0, valid1=0, y1=0, and no word was pushed or popped.
6. Randomized push/pop on both outputs for 1000 cycles with a scoreboard -> per-output order matches and no word is lost or duplicated. cntN always equals the scoreboard depth.
